// File: rtl/arb_types_pkg.sv
// Shared types and defaults for the single-port RAM arbiter.
// Holds the FSM state, grant encoding and counter sizing helper.
package arb_types_pkg;

    // 32-bit machine word as used across the CPU datapath.
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        I_ACC,
        D_ACC
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_I,
        GNT_D
    } grant_t;

    localparam int STARVE_MAX_DEF = 4;
    localparam int TIMEOUT_DEF    = 255;

    // Bits needed to hold 0..max, never less than one.
    function automatic int cnt_width(input int max);
        return (max < 2) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst_n (sync, active-low), inc, clr (wins over inc),
//        at_max (count has reached MAX).
module sat_counter
    import arb_types_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W   = cnt_width(MAX)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [W-1:0] count;

    assign at_max = (count == W'(MAX));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between instruction fetch and data access.
// Ports: CLK, nRST (sync, active-low); iREN/iaddr -> iwait/iload;
//        dREN/dWEN/daddr/dstore -> dwait/dload; ramREN/ramWEN/
//        ramaddr/ramstore/ramload/ramready to the RAM; err sticky timeout.
module ram_arbiter
    import arb_types_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic        err
);

    arb_state_t state;
    grant_t     grant;

    logic  dreq;
    logic  in_idle;
    logic  in_i;
    logic  in_d;
    logic  in_acc;
    logic  req_live;
    logic  done;
    logic  abort;
    logic  tmo;
    logic  starve_max;
    logic  tmo_max;
    word_t addr_sel;
    word_t store_sel;

    assign dreq    = dREN | dWEN;
    assign in_idle = (state == IDLE);
    assign in_i    = (state == I_ACC);
    assign in_d    = (state == D_ACC);
    assign in_acc  = in_i | in_d;

    // The granted requester must still be asking for the access.
    assign req_live = (in_i & iREN) | (in_d & dreq);
    assign done     = req_live & ramready;
    assign abort    = in_acc & ~req_live;
    // Counter sits at TIMEOUT-1 here, so this is the TIMEOUT-th
    // access cycle without ramready.
    assign tmo      = req_live & ~ramready & tmo_max;

    // Data wins unless instruction fetch has been starved too long.
    always_comb begin
        grant = GNT_NONE;
        if (dreq && iREN) begin
            grant = starve_max ? GNT_I : GNT_D;
        end else if (dreq) begin
            grant = GNT_D;
        end else if (iREN) begin
            grant = GNT_I;
        end
    end

    sat_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (CLK),
        .rst_n  (nRST),
        .inc    (in_idle & (grant == GNT_D) & iREN),
        .clr    (in_idle & ((grant == GNT_I) | ~iREN)),
        .at_max (starve_max)
    );

    sat_counter #(
        .MAX (TIMEOUT - 1)
    ) u_tmo (
        .clk    (CLK),
        .rst_n  (nRST),
        .inc    (in_acc & ~ramready),
        .clr    (in_idle),
        .at_max (tmo_max)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
            err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    unique case (grant)
                        GNT_I:   state <= I_ACC;
                        GNT_D:   state <= D_ACC;
                        default: state <= IDLE;
                    endcase
                end
                I_ACC, D_ACC: begin
                    if (done || abort || tmo) begin
                        state <= IDLE;
                    end
                    if (tmo) begin
                        err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes follow the live request so an abort drops them at once.
    always_comb begin
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        addr_sel  = '0;
        store_sel = '0;
        unique case (state)
            I_ACC: begin
                ramREN   = iREN;
                addr_sel = iaddr;
            end
            D_ACC: begin
                ramWEN    = dWEN;
                ramREN    = dREN & ~dWEN;
                addr_sel  = daddr;
                store_sel = dstore;
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

    assign ramaddr  = addr_sel;
    assign ramstore = store_sel;

    assign iwait = iREN & ~(in_i & ramready);
    assign dwait = dreq & ~(in_d & ramready);
    assign iload = (in_i & done) ? ramload : '0;
    assign dload = (in_d & done) ? ramload : '0;

endmodule
